// File: rtl/seq_arith_unit.sv
// seq_arith_unit: W-bit sequential arithmetic unit (LOAD / ADD / SUB / MUL)
// with a start/busy/done handshake, signed or unsigned operation, overflow
// and negative flags, and a sticky protocol-error flag.
//
// Handshake: start is sampled only on an edge where busy=0; that edge latches
// op/sgn/a/b and raises busy. busy stays high until the edge that writes the
// result, on which done pulses high for exactly one cycle and busy drops, so a
// new start presented during the done cycle is accepted (back-to-back). A
// start presented while busy=1 is ignored and sets err.
module seq_arith_unit #(
    parameter int W = 16
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           start,
    input  logic [1:0]     op,
    input  logic           sgn,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic           clr_err,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] result,
    output logic           ovf,
    output logic           neg,
    output logic           err,
    output logic [1:0]     state_dbg
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;
    localparam logic [1:0] OP_MUL  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t         state;
    logic [1:0]     op_q;
    logic           sgn_q;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;        // ALU operand B, or the shifting multiplier
    logic [2*W-1:0] mcand;      // multiplicand magnitude, shifted left each step
    logic [2*W-1:0] acc;
    logic           neg_prod;   // product must be negated in FIX
    logic [CW-1:0]  cnt;

    logic [W:0]     add_full;
    logic [W:0]     sub_full;
    logic [2*W-1:0] alu_res;
    logic           alu_ovf;
    logic [W-1:0]   a_mag;
    logic [W-1:0]   b_mag;
    logic [2*W-1:0] fix_val;

    assign state_dbg = state;

    // One extra bit captures the unsigned carry / borrow.
    assign add_full = {1'b0, a_q} + {1'b0, b_q};
    assign sub_full = {1'b0, a_q} - {1'b0, b_q};

    // Magnitudes stay W-bit unsigned, so -2^(W-1) maps to 2^(W-1) exactly.
    assign a_mag = (sgn && a[W-1]) ? -a : a;
    assign b_mag = (sgn && b[W-1]) ? -b : b;

    assign fix_val = neg_prod ? -acc : acc;

    // Single-cycle result and overflow for LOAD / ADD / SUB from latched operands.
    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (op_q)
            OP_LOAD: begin
                alu_res = {{W{sgn_q & a_q[W-1]}}, a_q};
            end
            OP_ADD: begin
                alu_res = {{W{sgn_q & add_full[W-1]}}, add_full[W-1:0]};
                alu_ovf = sgn_q ? ((a_q[W-1] == b_q[W-1]) && (add_full[W-1] != a_q[W-1]))
                                : add_full[W];
            end
            OP_SUB: begin
                alu_res = {{W{sgn_q & sub_full[W-1]}}, sub_full[W-1:0]};
                alu_ovf = sgn_q ? ((a_q[W-1] != b_q[W-1]) && (sub_full[W-1] != a_q[W-1]))
                                : sub_full[W];
            end
            default: begin
                alu_res = '0;
                alu_ovf = 1'b0;
            end
        endcase
    end

    // Control FSM, shift-add datapath, registered outputs and sticky error.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= S_IDLE;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            ovf      <= 1'b0;
            neg      <= 1'b0;
            err      <= 1'b0;
            op_q     <= OP_LOAD;
            sgn_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            mcand    <= '0;
            acc      <= '0;
            neg_prod <= 1'b0;
        end else begin
            done <= 1'b0;

            // A new violation wins over a clear in the same cycle.
            if (start && busy) begin
                err <= 1'b1;
            end else if (clr_err) begin
                err <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (busy) begin
                        // Complete a pending LOAD / ADD / SUB.
                        result <= alu_res;
                        ovf    <= alu_ovf;
                        neg    <= sgn_q & alu_res[2*W-1];
                        done   <= 1'b1;
                        busy   <= 1'b0;
                    end else if (start) begin
                        op_q  <= op;
                        sgn_q <= sgn;
                        busy  <= 1'b1;
                        if (op == OP_MUL) begin
                            a_q      <= a;
                            mcand    <= {{W{1'b0}}, a_mag};
                            b_q      <= b_mag;
                            neg_prod <= sgn & (a[W-1] ^ b[W-1]);
                            acc      <= '0;
                            cnt      <= '0;
                            state    <= S_MUL;
                        end else begin
                            a_q <= a;
                            b_q <= b;
                        end
                    end
                end
                S_MUL: begin
                    if (b_q[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand <= mcand << 1;
                    b_q   <= b_q >> 1;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    result <= fix_val;
                    ovf    <= 1'b0;
                    neg    <= sgn_q & fix_val[2*W-1];
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_arith_unit.sv
// tb_seq_arith_unit: randomized and directed bench for seq_arith_unit with a
// queue-based scoreboard and an arithmetic reference model.
module tb_seq_arith_unit;

    localparam int W   = 16;
    localparam int W8  = 8;
    localparam int EW  = 32 + 2 + 2 * W;
    localparam int EW8 = 32 + 2 + 2 * W8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic           rst;
    logic           start;
    logic [1:0]     op;
    logic           sgn;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           clr_err;
    logic           busy;
    logic           done;
    logic [2*W-1:0] result;
    logic           ovf;
    logic           neg;
    logic           err;
    logic [1:0]     state_dbg;

    logic            start8;
    logic [1:0]      op8;
    logic            sgn8;
    logic [W8-1:0]   a8;
    logic [W8-1:0]   b8;
    logic            busy8;
    logic            done8;
    logic [2*W8-1:0] result8;
    logic            ovf8;
    logic            neg8;
    logic            err8;
    logic [1:0]      state_dbg8;

    seq_arith_unit #(.W(W)) u_dut (
        .CLK(clk), .RST(rst), .start(start), .op(op), .sgn(sgn), .a(a), .b(b),
        .clr_err(clr_err), .busy(busy), .done(done), .result(result), .ovf(ovf),
        .neg(neg), .err(err), .state_dbg(state_dbg)
    );

    seq_arith_unit #(.W(W8)) u_dut8 (
        .CLK(clk), .RST(rst), .start(start8), .op(op8), .sgn(sgn8), .a(a8), .b(b8),
        .clr_err(1'b0), .busy(busy8), .done(done8), .result(result8), .ovf(ovf8),
        .neg(neg8), .err(err8), .state_dbg(state_dbg8)
    );

    int tests = 0;
    int fails = 0;

    logic [EW-1:0]  exp_q[$];
    logic [EW8-1:0] exp8_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // Works on true integer values: interpret operands, do the arithmetic,
    // decide overflow from the mathematical result, then wrap to the output width.
    function automatic logic [63:0] model(input int w, input logic [1:0] o, input logic s,
                                          input logic [31:0] x, input logic [31:0] y,
                                          output logic vo, output logic vn);
        longint m_w, va, vb, full, lo;
        logic [63:0] r;
        logic [63:0] mask2;
        m_w = longint'(1) << w;
        va = longint'(x);
        vb = longint'(y);
        if (s && x[w-1]) va = va - m_w;
        if (s && y[w-1]) vb = vb - m_w;
        vo = 1'b0;
        case (o)
            2'd0: full = va;
            2'd1, 2'd2: begin
                full = (o == 2'd1) ? va + vb : va - vb;
                if (s) vo = (full < -(m_w / 2)) || (full >= m_w / 2);
                else   vo = (full < 0) || (full >= m_w);
                lo = full & (m_w - 1);
                if (s && lo >= m_w / 2) lo = lo - m_w;
                full = lo;
            end
            default: full = va * vb;
        endcase
        mask2 = (64'd1 << (2 * w)) - 64'd1;
        r = full;
        r = r & mask2;
        vn = s & r[2 * w - 1];
        return r;
    endfunction

    // ---------------- drivers ----------------
    task automatic issue_exp(input logic [1:0] o, input logic s, input logic [W-1:0] x,
                             input logic [W-1:0] y, input logic [2*W-1:0] er,
                             input logic eo, input logic en);
        int guard = 0;
        int lat;
        while (busy === 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) check("issue_wait_timeout", 64'(guard), 64'(0));
        lat = (o == 2'b11) ? W + 1 : 1;
        op = o; sgn = s; a = x; b = y; start = 1'b1;
        exp_q.push_back({32'(cyc + 1 + lat), eo, en, er});
        @(negedge clk);
        start = 1'b0;
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return {1'b1, {(W-1){1'b0}}};
            3:       return {1'b0, {(W-1){1'b1}}};
            default: return W'($urandom);
        endcase
    endfunction

    task automatic issue_rand();
        logic [1:0]  o;
        logic        s;
        logic [W-1:0] x, y;
        logic [63:0] r;
        logic        vo, vn;
        o = 2'($urandom_range(0, 3));
        s = 1'($urandom_range(0, 1));
        x = pick();
        y = pick();
        r = model(W, o, s, 32'(x), 32'(y), vo, vn);
        issue_exp(o, s, x, y, r[2*W-1:0], vo, vn);
    endtask

    task automatic issue8_exp(input logic [1:0] o, input logic s, input logic [W8-1:0] x,
                              input logic [W8-1:0] y, input logic [2*W8-1:0] er,
                              input logic eo, input logic en);
        int guard = 0;
        int lat;
        while (busy8 === 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) check("issue8_wait_timeout", 64'(guard), 64'(0));
        lat = (o == 2'b11) ? W8 + 1 : 1;
        op8 = o; sgn8 = s; a8 = x; b8 = y; start8 = 1'b1;
        exp8_q.push_back({32'(cyc + 1 + lat), eo, en, er});
        @(negedge clk);
        start8 = 1'b0;
    endtask

    task automatic wait_drain();
        int guard = 0;
        while ((exp_q.size() != 0 || exp8_q.size() != 0 || busy || busy8) && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 500) check("drain_timeout", 64'(exp_q.size() + exp8_q.size()), 64'(0));
    endtask

    // ---------------- scoreboard monitors ----------------
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 64'(result), 64'(0));
                if (result == '0) begin
                    fails++;
                    $display("FAIL unexpected_done: got done=1, expected no completion (cycle %0d)", cyc);
                end
            end else begin
                e = exp_q.pop_front();
                check("done_cycle", 64'(cyc), 64'(e[EW-1 -: 32]));
                check("result", 64'(result), 64'(e[2*W-1:0]));
                check("ovf", 64'(ovf), 64'(e[2*W+1]));
                check("neg", 64'(neg), 64'(e[2*W]));
            end
        end
    end

    always @(negedge clk) begin
        logic [EW8-1:0] e;
        if (!rst && done8) begin
            if (exp8_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done8: got done=1, expected no completion (cycle %0d)", cyc);
            end else begin
                e = exp8_q.pop_front();
                check("done_cycle8", 64'(cyc), 64'(e[EW8-1 -: 32]));
                check("result8", 64'(result8), 64'(e[2*W8-1:0]));
                check("ovf8", 64'(ovf8), 64'(e[2*W8+1]));
                check("neg8", 64'(neg8), 64'(e[2*W8]));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; start = 1'b0; op = '0; sgn = 1'b0; a = '0; b = '0; clr_err = 1'b0;
        start8 = 1'b0; op8 = '0; sgn8 = 1'b0; a8 = '0; b8 = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_result", 64'(result), 64'(0));
        check("rst_flags", 64'({ovf, neg, err}), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        // Directed arithmetic cases, issued back-to-back where the DUT allows.
        issue_exp(2'b01, 1'b0, 16'hFFFF, 16'h0001, 32'h0000_0000, 1'b1, 1'b0);
        issue_exp(2'b10, 1'b1, 16'h8000, 16'h0001, 32'h0000_7FFF, 1'b1, 1'b0);
        issue_exp(2'b10, 1'b0, 16'h8000, 16'h0001, 32'h0000_7FFF, 1'b0, 1'b0);
        issue_exp(2'b11, 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 1'b0, 1'b0);
        issue_exp(2'b11, 1'b1, 16'hFFFD, 16'h0005, 32'hFFFF_FFF1, 1'b0, 1'b1);
        issue_exp(2'b11, 1'b1, 16'h8000, 16'h8000, 32'h4000_0000, 1'b0, 1'b0);
        issue_exp(2'b00, 1'b1, 16'h8001, 16'h0000, 32'hFFFF_8001, 1'b0, 1'b1);
        issue_exp(2'b00, 1'b0, 16'h8001, 16'h0000, 32'h0000_8001, 1'b0, 1'b0);
        issue_exp(2'b01, 1'b0, 16'h1234, 16'h1111, 32'h0000_2345, 1'b0, 1'b0);
        issue_exp(2'b01, 1'b1, 16'h7FFF, 16'h0001, 32'hFFFF_8000, 1'b1, 1'b1);
        issue_exp(2'b10, 1'b0, 16'h0003, 16'h0005, 32'h0000_FFFE, 1'b1, 1'b0);
        wait_drain();

        // Protocol violation during MUL: ignored, err set and sticky, then cleared.
        issue_exp(2'b11, 1'b0, 16'h0003, 16'h0007, 32'h0000_0015, 1'b0, 1'b0);
        @(negedge clk);
        op = 2'b01; a = 16'h1111; b = 16'h2222; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("err_set", 64'(err), 64'(1));
        wait_drain();
        check("err_sticky", 64'(err), 64'(1));
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check("err_clear", 64'(err), 64'(0));

        // Violation and clear in the same cycle: set wins.
        issue_exp(2'b11, 1'b1, 16'hFFFF, 16'h0002, 32'hFFFF_FFFE, 1'b0, 1'b1);
        start = 1'b1; clr_err = 1'b1;
        @(negedge clk);
        start = 1'b0; clr_err = 1'b0;
        check("err_set_wins", 64'(err), 64'(1));
        wait_drain();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check("err_clear2", 64'(err), 64'(0));

        // Reset in the middle of a MUL discards it; no done follows.
        issue_exp(2'b11, 1'b0, 16'h00FF, 16'h0101, 32'h0000_FFFF, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        void'(exp_q.pop_back());
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_done", 64'(done), 64'(0));
        check("midrst_result", 64'(result), 64'(0));
        check("midrst_flags", 64'({ovf, neg, err}), 64'(0));
        repeat (W + 5) @(negedge clk);

        // Randomized traffic against the reference model.
        repeat (150) issue_rand();
        wait_drain();

        // Narrow build: signed most-negative squared, plus random ops.
        issue8_exp(2'b11, 1'b1, 8'h80, 8'h80, 16'h4000, 1'b0, 1'b0);
        repeat (30) begin
            logic [1:0]  o;
            logic        s;
            logic [7:0]  x, y;
            logic [63:0] r;
            logic        vo, vn;
            o = 2'($urandom_range(0, 3));
            s = 1'($urandom_range(0, 1));
            x = 8'($urandom);
            y = 8'($urandom);
            r = model(W8, o, s, 32'(x), 32'(y), vo, vn);
            issue8_exp(o, s, x, y, r[15:0], vo, vn);
        end
        wait_drain();

        check("queue_empty", 64'(exp_q.size() + exp8_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seq_arith_unit.md
Name: seq_arith_unit

Overview:
Parametrised W-bit sequential arithmetic unit with start/busy/done handshake. Supports LOAD, ADD, SUB and a shift-add MUL with a full 2W-bit product, in signed or unsigned mode. Reports overflow and negative flags, and holds a sticky protocol-error flag. Sits behind the top-level pin decoder as the generalised successor of the fixed 16-bit arithmetic datapath.

Parameters:
W, 16, operand width in bits (legal range 4..32); result width is 2W.

Ports:
CLK     in   1     clock; all state updates on rising edge
RST     in   1     synchronous reset, active high
start   in   1     request; sampled only while busy=0
op      in   2     00 LOAD, 01 ADD, 10 SUB, 11 MUL; sampled with start
sgn     in   1     1 = two's-complement operands, 0 = unsigned; sampled with start
a       in   W     operand A; sampled with start
b       in   W     operand B; sampled with start
clr_err in   1     clears err
busy    out  1     operation in progress
done    out  1     one-cycle pulse; result and flags valid from this cycle
result  out  2W    result; held until the next accepted operation completes
ovf     out  1     overflow flag, held with result
neg     out  1     negative flag, held with result
err     out  1     sticky protocol-error flag

Behaviour:
- Reset: RST=1 at an edge forces state IDLE, counter 0, busy=0, done=0, result=0, ovf=0, neg=0, err=0. Applies mid-operation; a partial result is discarded.
- States: IDLE, MUL, FIX.
  - IDLE: start=1 accepts the request. a, b, op and sgn are latched, and busy goes to 1 on the same edge.
  - LOAD, ADD and SUB complete on the next edge: result, flags and done=1 are written, busy returns to 0, and the state stays IDLE. Latency is 1 cycle.
  - MUL on accept: latch |a| and |b| (magnitudes if sgn=1, raw otherwise), latch sign = sgn & (a[W-1]^b[W-1]), clear the accumulator and counter, go to MUL.
  - MUL: one multiplier bit per cycle, LSB first. The accumulator is 2W bits, and the counter counts 0..W-1. After W cycles the state moves to FIX.
  - FIX: result = sign ? -acc : acc. Write result and flags, assign done=1 and busy=0, and return to IDLE. MUL latency is W+1 cycles, start edge to done edge.
- done is high for exactly one cycle. start in the cycle done=1 is accepted, since busy=0, which allows back-to-back operation.
- start=1 while busy=1 is ignored; the operation continues unchanged and err is set to 1. err stays 1 until RST, or until clr_err=1 with no new violation in that cycle. If a violation and clr_err coincide, set wins.
- LOAD: the low W bits of result equal a, and the upper W bits are the extension. ovf=0.
- ADD/SUB: the low W bits of result hold a+b or a-b, modulo 2^W. The upper W bits are replicate(result[W-1]) if sgn=1, else 0.
- ovf for ADD/SUB:
  - unsigned ADD: carry out.
  - unsigned SUB: borrow (a<b).
  - signed ADD/SUB: two's-complement overflow, i.e. operand signs that imply a result sign different from the one produced.
- MUL: the full 2W-bit product, so ovf=0 always. Signed -2^(W-1) operands are correct because magnitudes are W-bit unsigned.
- neg = sgn & result[2W-1], updated with result. Unsigned mode gives neg=0.
- Outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
- W=16, ADD, sgn=0, a=0xFFFF, b=0x0001 -> done 1 cycle after start; result=0x00000000, ovf=1, neg=0.
- W=16, SUB, sgn=1, a=0x8000, b=0x0001 -> result=0x00007FFF, ovf=1, neg=0; same op with sgn=0 -> result=0x00007FFF, ovf=0.
- W=16, MUL, sgn=0, a=0xFFFF, b=0xFFFF -> busy high for 17 cycles, done exactly 17 cycles after start; result=0xFFFE0001, ovf=0, neg=0.
- W=16, MUL, sgn=1, a=0xFFFD (-3), b=0x0005 -> result=0xFFFFFFF1, neg=1; with a=0x8000, b=0x8000 -> result=0x40000000, neg=0.
- Protocol violation: MUL started, then start=1 at cycle 3 -> operation unaffected, err=1, err persists; clr_err pulse -> err=0. Back-to-back: start with ADD in the done cycle -> accepted, done 1 cycle later.
- RST=1 during cycle 5 of MUL -> next cycle busy=0, done=0, result=0, flags=0, and no done pulse follows. W=8 build: signed 0x80 * 0x80 -> result=0x4000 after 9 cycles.
